rifl_rx_frame_aligner: RTL

- Sits directly downstream of the GT wrapper's RX user-data port, in the rx_gt_clk domain.
- Consumes the raw, unaligned DWIDTH-bit words from the transceiver.
- Finds the 2-bit sync header that starts each FRAME_WIDTH-bit frame using bit-slip plus word-phase search.
- Emits aligned words with start-of-frame marking, and drives the rx_aligned status back into the GT wrapper's RX-good qualification.

---
 rtl/rifl_rx_frame_aligner_if.sv | 33 +++
 rtl/rifl_rx_frame_aligner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rifl_rx_frame_aligner_if.sv
// Purpose : bundles the raw GT word input and the aligned-word / status outputs of the RX frame aligner.
// Latency : none (signal container only).
// Backpressure: none; the GT delivers one word per clock and the consumer must accept every word.
//
// Ports (master = aligner side):
//   gt_rx_data       raw unaligned transceiver word
//   rx_data          aligned word
//   rx_data_valid    rx_data is locked payload
//   rx_sof           rx_data is word 0 of a frame
//   rx_aligned       lock status back to the GT wrapper
//   bit_offset       current bit-slip position
//   word_phase_slips saturating slip count since reset
interface rifl_rx_frame_aligner_if #(
  parameter int DWIDTH = 64
);
  logic [DWIDTH-1:0]         gt_rx_data;
  logic [DWIDTH-1:0]         rx_data;
  logic                      rx_data_valid;
  logic                      rx_sof;
  logic                      rx_aligned;
  logic [$clog2(DWIDTH)-1:0] bit_offset;
  logic [15:0]               word_phase_slips;

  modport master (
    input  gt_rx_data,
    output rx_data, rx_data_valid, rx_sof, rx_aligned, bit_offset, word_phase_slips
  );

  modport slave (
    output gt_rx_data,
    input  rx_data, rx_data_valid, rx_sof, rx_aligned, bit_offset, word_phase_slips
  );
endinterface

// File: rtl/rifl_rx_frame_aligner.sv
// Purpose : finds the 2-bit sync header of each frame in the raw GT word stream by bit-slip plus
//           word-phase search, then emits aligned words with start-of-frame marking and lock status.
// Latency : fixed; the first bit of an aligned word appears on rx_data two clocks after the GT word
//           that carries it was presented.
// Backpressure: none; one word in and one word out every clock.
//
// Ports: clk / rst_n (async active-low) plain; everything else on the master modport of
//        rifl_rx_frame_aligner_if (gt_rx_data in; rx_data, rx_data_valid, rx_sof, rx_aligned,
//        bit_offset, word_phase_slips out).
module rifl_rx_frame_aligner #(
  parameter int DWIDTH      = 64,
  parameter int FRAME_WIDTH = 256,
  parameter int LOCK_CNT    = 64,
  parameter int ERR_WINDOW  = 1024,
  parameter int ERR_LIMIT   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rifl_rx_frame_aligner_if.master  bus
);

  localparam int RATIO = FRAME_WIDTH / DWIDTH;
  localparam int FCW   = $clog2(RATIO);
  localparam int SCW   = $clog2(RATIO) + 1;
  localparam int BW    = $clog2(DWIDTH);
  localparam int GW    = $clog2(LOCK_CNT + 1);
  localparam int WW    = $clog2(ERR_WINDOW + 1);
  localparam int EW    = $clog2(ERR_LIMIT + 1);

  localparam logic [SCW-1:0] SLIP_WRAP = SCW'(RATIO);
  localparam logic [BW-1:0]  BO_LAST   = BW'(DWIDTH - 1);
  localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0]  WIN_END   = WW'(ERR_WINDOW);
  localparam logic [EW-1:0]  ERR_END   = EW'(ERR_LIMIT);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] prev;
  logic              prev_vld;     // prev holds a real GT word (not the reset value)
  logic [FCW-1:0]    fc;
  logic [SCW-1:0]    slip_cnt;     // consecutive word slips at the current bit offset
  logic [BW-1:0]     bit_off;
  logic [15:0]       slips;
  logic [GW-1:0]     good_cnt, good_nxt;
  logic [WW-1:0]     win_cnt, win_nxt, win_inc;
  logic [EW-1:0]     err_cnt, err_nxt, err_inc;

  logic [2*DWIDTH-1:0] concat;
  logic [DWIDTH-1:0]   cand;
  logic [1:0]          hdr;
  logic                hdr_ok;
  logic                check;
  logic                slip;
  logic                word_slip;
  logic                bit_slip;

  logic [DWIDTH-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_sof_q;
  logic              rx_aligned_q;

  assign concat = {prev, bus.gt_rx_data};
  assign cand   = concat[2*DWIDTH-1-int'(bit_off) -: DWIDTH];
  assign hdr    = cand[DWIDTH-1 -: 2];

  // Checks wait for prev to hold real data so a clean stream from reset locks without slipping.
  assign check  = prev_vld && (fc == '0);

  // Only the two legal patterns qualify; an unknown header falls to the default (invalid).
  always_comb begin
    hdr_ok = 1'b0;
    case (hdr)
      2'b01, 2'b10: hdr_ok = 1'b1;
      default:      hdr_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    win_nxt   = win_cnt;
    err_nxt   = err_cnt;
    slip      = 1'b0;
    win_inc   = win_cnt + 1'b1;
    err_inc   = err_cnt + {{(EW-1){1'b0}}, ~hdr_ok};
    if (check) begin
      case (state)
        HUNT: begin
          if (hdr_ok) begin
            if (good_cnt == GOOD_LAST) begin
              state_nxt = LOCKED;
              good_nxt  = '0;
            end else begin
              good_nxt = good_cnt + 1'b1;
            end
          end else begin
            good_nxt = '0;
            slip     = 1'b1;
          end
        end
        LOCKED: begin
          // Loss of lock is tested first so it wins over a coincident window end.
          if (err_inc == ERR_END) begin
            state_nxt = HUNT;
            good_nxt  = '0;
            win_nxt   = '0;
            err_nxt   = '0;
            slip      = 1'b1;
          end else if (win_inc == WIN_END) begin
            win_nxt = '0;
            err_nxt = '0;
          end else begin
            win_nxt = win_inc;
            err_nxt = err_inc;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Each bit offset gets RATIO word slips (one full lap of phases) before the bit offset moves.
  assign word_slip = slip && (slip_cnt != SLIP_WRAP);
  assign bit_slip  = slip && (slip_cnt == SLIP_WRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      prev         <= '0;
      prev_vld     <= 1'b0;
      fc           <= '0;
      slip_cnt     <= '0;
      bit_off      <= '0;
      slips        <= '0;
      good_cnt     <= '0;
      win_cnt      <= '0;
      err_cnt      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_sof_q     <= 1'b0;
      rx_aligned_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev     <= bus.gt_rx_data;
      prev_vld <= 1'b1;
      good_cnt <= good_nxt;
      win_cnt  <= win_nxt;
      err_cnt  <= err_nxt;

      // Holding fc for one cycle re-labels the following word as word 0.
      if (prev_vld && !word_slip) begin
        fc <= fc + 1'b1;
      end

      if (word_slip) begin
        slip_cnt <= slip_cnt + 1'b1;
      end else if (bit_slip) begin
        slip_cnt <= '0;
        bit_off  <= (bit_off == BO_LAST) ? '0 : bit_off + 1'b1;
      end

      if (slip && (slips != 16'hFFFF)) begin
        slips <= slips + 1'b1;
      end

      rx_data_q    <= cand;
      rx_aligned_q <= (state_nxt == LOCKED);
      rx_valid_q   <= (state_nxt == LOCKED) && prev_vld;
      rx_sof_q     <= check && (state_nxt == LOCKED);
    end
  end

  assign bus.rx_data          = rx_data_q;
  assign bus.rx_data_valid    = rx_valid_q;
  assign bus.rx_sof           = rx_sof_q;
  assign bus.rx_aligned       = rx_aligned_q;
  assign bus.bit_offset       = bit_off;
  assign bus.word_phase_slips = slips;

endmodule
